// File: rtl/counter0_6_checker_if.sv
// Bundles the sampled count bits (C,B,A) and the checker's status outputs.
// master: the side presenting the count; slave: the checker itself.
interface counter0_6_checker_if #(
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 8
);
  logic              C;
  logic              B;
  logic              A;
  logic              LOCKED;
  logic              ERR;
  logic              OOR;
  logic [ERR_W-1:0]  ERR_CNT;
  logic [WRAP_W-1:0] WRAP_CNT;

  modport master (
    output C, B, A,
    input  LOCKED, ERR, OOR, ERR_CNT, WRAP_CNT
  );

  modport slave (
    input  C, B, A,
    output LOCKED, ERR, OOR, ERR_CNT, WRAP_CNT
  );
endinterface

// File: rtl/counter0_6_checker.sv
// Sequence checker for a modulo-(MAX_VAL+1) up-counter: locks, flags deviations, counts wraps.
// Optional macro STALL_TOL_EN: a repeated sample is treated as a legal hold instead of a mismatch.
module counter0_6_checker #(
  parameter int unsigned MAX_VAL  = 6,
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  counter0_6_checker_if.slave   bus
);

  localparam logic [2:0]        MAX_V    = 3'(MAX_VAL);
  localparam logic [3:0]        LOCK_V   = 4'(LOCK_LEN);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACQ,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  logic [2:0]          r_prev;
  logic [3:0]          r_run;
  logic                r_locked;
  logic                r_err;
  logic                r_oor;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [WRAP_W-1:0]   r_wrap_cnt;

  state_t              w_state_nxt;
  logic [3:0]          w_run_nxt;
  logic [3:0]          w_run_inc;
  logic                w_err_nxt;
  logic                w_oor_nxt;
  logic [ERR_W-1:0]    w_err_cnt_nxt;
  logic [WRAP_W-1:0]   w_wrap_cnt_nxt;

  logic [2:0]          w_cur;
  logic [2:0]          w_exp;
  logic                w_match;
  logic                w_hold;
  logic                w_oor;
  logic                w_wrap;

  assign w_cur     = {bus.C, bus.B, bus.A};
  assign w_exp     = (r_prev == MAX_V) ? 3'd0 : 3'(r_prev + 3'd1);
  assign w_match   = (w_cur == w_exp);
  assign w_oor     = (w_cur > MAX_V);
  assign w_wrap    = (r_prev == MAX_V) && (w_cur == 3'd0);
  assign w_run_inc = 4'(r_run + 4'd1);

`ifdef STALL_TOL_EN
  // A paused counter presents the same value again; tolerate it.
  assign w_hold = (w_cur == r_prev);
`else
  assign w_hold = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run;
    w_err_nxt      = 1'b0;
    w_oor_nxt      = 1'b0;
    w_err_cnt_nxt  = r_err_cnt;
    w_wrap_cnt_nxt = r_wrap_cnt;

    unique case (r_state)
      ST_EMPTY: begin
        w_state_nxt = ST_ACQ;
        w_run_nxt   = 4'd0;
      end

      ST_ACQ: begin
        w_oor_nxt = w_oor;
        if (w_match) begin
          if (w_run_inc == LOCK_V) begin
            w_state_nxt = ST_LOCKED;
            w_run_nxt   = 4'd0;
          end else begin
            w_run_nxt = w_run_inc;
          end
        end else if (!w_hold) begin
          w_run_nxt = 4'd0;
        end
      end

      ST_LOCKED: begin
        w_oor_nxt = w_oor;
        if (w_match) begin
          if (w_wrap) begin
            w_wrap_cnt_nxt = r_wrap_cnt + WRAP_ONE;
          end
        end else if (!w_hold) begin
          // Deviation: the bad sample still becomes prev so re-lock can start from it.
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_ACQ;
          w_run_nxt   = 4'd0;
          if (r_err_cnt != ERR_MAX) begin
            w_err_cnt_nxt = r_err_cnt + ERR_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_EMPTY;
        w_run_nxt   = 4'd0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_EMPTY;
      r_prev     <= 3'd0;
      r_run      <= 4'd0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_oor      <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_cur;
      r_run      <= w_run_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_err      <= w_err_nxt;
      r_oor      <= w_oor_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_wrap_cnt <= w_wrap_cnt_nxt;
    end
  end

  assign bus.LOCKED   = r_locked;
  assign bus.ERR      = r_err;
  assign bus.OOR      = r_oor;
  assign bus.ERR_CNT  = r_err_cnt;
  assign bus.WRAP_CNT = r_wrap_cnt;

endmodule

// File: tb/tb_counter0_6_checker.sv
// Scoreboard bench: two checkers (ERR_W=8 and ERR_W=2) share one directed count stream;
// expected flags per step are written by hand, expected counters follow from those flags.
module tb_counter0_6_checker;

  logic CLK;
  logic RST;

  counter0_6_checker_if #(.ERR_W(8), .WRAP_W(8)) bus_a ();
  counter0_6_checker_if #(.ERR_W(2), .WRAP_W(8)) bus_b ();

  counter0_6_checker #(.MAX_VAL(6), .LOCK_LEN(2), .ERR_W(8), .WRAP_W(8)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  counter0_6_checker #(.MAX_VAL(6), .LOCK_LEN(2), .ERR_W(2), .WRAP_W(8)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         idx;
    bit         lk;
    bit         er;
    bit         oo;
    logic [7:0] ec_a;
    logic [1:0] ec_b;
    logic [7:0] wc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_idx = 0;
  int   m_ec_a = 0;
  int   m_ec_b = 0;
  int   m_wc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one sample for the next rising edge and queue the response it must produce.
  task automatic step(input logic [2:0] v, input bit rst, input bit lk, input bit er,
                      input bit oo, input bit wr);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    {bus_a.C, bus_a.B, bus_a.A} = v;
    {bus_b.C, bus_b.B, bus_b.A} = v;
    if (rst) begin
      m_ec_a = 0;
      m_ec_b = 0;
      m_wc   = 0;
    end else begin
      if (er && m_ec_a < 255) m_ec_a++;
      if (er && m_ec_b < 3)   m_ec_b++;
      if (wr) m_wc = (m_wc + 1) % 256;
    end
    e.idx  = step_idx;
    e.lk   = lk;
    e.er   = er;
    e.oo   = oo;
    e.ec_a = 8'(m_ec_a);
    e.ec_b = 2'(m_ec_b);
    e.wc   = 8'(m_wc);
    q.push_back(e);
    step_idx++;
  endtask

  // Locked at some value: inject a wrong one, then two correct steps to re-lock.
  task automatic dev(input logic [2:0] bad_v, input logic [2:0] a, input logic [2:0] b);
    step(bad_v, 0, 0, 1, 0, 0);
    step(a,     0, 0, 0, 0, 0);
    step(b,     0, 1, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check($sformatf("locked_a@%0d", e.idx), 32'(bus_a.LOCKED),   32'(e.lk));
        check($sformatf("locked_b@%0d", e.idx), 32'(bus_b.LOCKED),   32'(e.lk));
        check($sformatf("err_a@%0d",    e.idx), 32'(bus_a.ERR),      32'(e.er));
        check($sformatf("err_b@%0d",    e.idx), 32'(bus_b.ERR),      32'(e.er));
        check($sformatf("oor_a@%0d",    e.idx), 32'(bus_a.OOR),      32'(e.oo));
        check($sformatf("oor_b@%0d",    e.idx), 32'(bus_b.OOR),      32'(e.oo));
        check($sformatf("errcnt_a@%0d", e.idx), 32'(bus_a.ERR_CNT),  32'(e.ec_a));
        check($sformatf("errcnt_b@%0d", e.idx), 32'(bus_b.ERR_CNT),  32'(e.ec_b));
        check($sformatf("wrap_a@%0d",   e.idx), 32'(bus_a.WRAP_CNT), 32'(e.wc));
        check($sformatf("wrap_b@%0d",   e.idx), 32'(bus_b.WRAP_CNT), 32'(e.wc));
      end
    end
  end

  initial begin : stimulus
    RST = 1'b1;
    {bus_a.C, bus_a.B, bus_a.A} = 3'd0;
    {bus_b.C, bus_b.B, bus_b.A} = 3'd0;

    // Reset, then first sample fills prev, lock on the third edge.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(2, 0, 1, 0, 0, 0);
    for (int v = 3; v <= 6; v++) step(3'(v), 0, 1, 0, 0, 0);

    // Three full locked cycles -> three 6->0 wraps.
    repeat (2) begin
      step(0, 0, 1, 0, 0, 1);
      for (int v = 1; v <= 6; v++) step(3'(v), 0, 1, 0, 0, 0);
    end
    step(0, 0, 1, 0, 0, 1);

    // Locked at 4, inject 2, re-lock after 3,4.
    for (int v = 1; v <= 4; v++) step(3'(v), 0, 1, 0, 0, 0);
    step(2, 0, 0, 1, 0, 0);
    step(3, 0, 0, 0, 0, 0);
    step(4, 0, 1, 0, 0, 0);
    step(5, 0, 1, 0, 0, 0);
    step(6, 0, 1, 0, 0, 0);

    // Out-of-range while locked, then again in ACQ; 7->0 is a correct step.
    step(7, 0, 0, 1, 1, 0);
    step(7, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);

    // Five more deviations: ERR_W=2 counter saturates at 3.
    dev(3, 4, 5);
    dev(0, 1, 2);
    dev(4, 5, 6);
    dev(1, 2, 3);
    dev(1, 2, 3);

    // Reset while locked clears everything.
    step(3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(2, 0, 1, 0, 0, 0);
    step(3, 0, 1, 0, 0, 0);

    // Locked, hold value 3 for a second clock.
`ifdef STALL_TOL_EN
    step(3, 0, 1, 0, 0, 0);
    step(4, 0, 1, 0, 0, 0);
    step(5, 0, 1, 0, 0, 0);
`else
    step(3, 0, 0, 1, 0, 0);
    step(4, 0, 0, 0, 0, 0);
    step(5, 0, 1, 0, 0, 0);
`endif

    // An out-of-range first sample after reset is only stored, not flagged.
    step(0, 1, 0, 0, 0, 0);
    step(7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) check("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
